// File: rtl/d_write_buffer.sv
// Posted-write buffer between a write-through data cache and main memory.
// Writes retire into a FIFO and drain in the background; cached read misses forward or bypass.
module d_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   c_a,
  input  logic [31:0]   c_din,
  output logic [31:0]   c_dout,
  input  logic          c_strobe,
  input  logic          c_rw,
  input  logic          uncached,
  output logic          c_ready,
  output logic [31:0]   m_a,
  output logic [31:0]   m_din,
  input  logic [31:0]   m_dout,
  output logic          m_strobe,
  output logic          m_rw,
  input  logic          m_ready,
  output logic          wb_empty,
  output logic [PW:0]   wb_count,
  output logic [1:0]    dbg_state
);

  // Handshake: the cache holds c_strobe/c_rw/c_a/c_din stable until a cycle with c_ready=1;
  // that cycle completes the request. Memory holds m_* stable while m_strobe=1 and ends the
  // request with a single-cycle m_ready pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   buf_a [DEPTH];
  logic [31:0]   buf_d [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic          full;
  logic          wr_req;
  logic          rd_req;
  logic          push;
  logic          pop;
  logic          rd_done;
  logic          rd_go;
  logic          fwd_match;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] fwd_idx;

  assign full     = (count == (PW+1)'(DEPTH));
  assign wr_req   = c_strobe & c_rw;
  assign rd_req   = c_strobe & ~c_rw;
  assign push     = wr_req & ~full;
  assign pop      = (state == WRITE) & m_ready;
  assign rd_done  = (state == READ) & m_ready;
  assign wb_empty = (count == '0);
  assign wb_count = count;
  assign dbg_state = state;

  // Walk entries oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_match = 1'b0;
    fwd_data  = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PW'(i);
      if (((PW+1)'(i) < count) && (buf_a[fwd_idx][31:2] == c_a[31:2])) begin
        fwd_match = 1'b1;
        fwd_data  = buf_d[fwd_idx];
      end
    end
  end

  assign fwd_hit = rd_req & ~uncached & fwd_match;
  assign rd_go   = rd_req & ~fwd_hit & (~uncached | wb_empty);

  always_comb begin
    c_ready = 1'b0;
    c_dout  = '0;
    if (wr_req) begin
      c_ready = ~full;
    end else if (fwd_hit) begin
      c_ready = 1'b1;
      c_dout  = fwd_data;
    end else if (rd_req & rd_done) begin
      c_ready = 1'b1;
      c_dout  = m_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_a[tail] <= c_a;
      buf_d[tail] <= c_din;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // A started memory transaction always runs to its m_ready; reads win only at IDLE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      m_a      <= '0;
      m_din    <= '0;
      m_strobe <= 1'b0;
      m_rw     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_go) begin
            m_a      <= c_a;
            m_rw     <= 1'b0;
            m_strobe <= 1'b1;
            state    <= READ;
          end else if (!wb_empty) begin
            m_a      <= buf_a[head];
            m_din    <= buf_d[head];
            m_rw     <= 1'b1;
            m_strobe <= 1'b1;
            state    <= WRITE;
          end
        end
        READ: begin
          if (m_ready) begin
            m_strobe <= 1'b0;
            state    <= IDLE;
          end
        end
        WRITE: begin
          if (m_ready) begin
            m_strobe <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          m_strobe <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_write_buffer.sv
// Bench for d_write_buffer: memory responder with a write scoreboard, one task per scenario.
module tb_d_write_buffer;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
  localparam int W     = 64;

  logic          clk;
  logic          clrn;
  logic [31:0]   c_a, c_din, c_dout;
  logic          c_strobe, c_rw, uncached, c_ready;
  logic [31:0]   m_a, m_din, m_dout;
  logic          m_strobe, m_rw, m_ready;
  logic          wb_empty;
  logic [PW:0]   wb_count;
  logic [1:0]    dbg_state;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  exp_q[$];
  logic [31:0]   rd_log[$];
  int            rd_wcnt[$];
  int            total_wr = 0;
  bit            mem_hold = 0;
  int            mem_wait = 0;

  d_write_buffer #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk), .clrn(clrn),
    .c_a(c_a), .c_din(c_din), .c_dout(c_dout),
    .c_strobe(c_strobe), .c_rw(c_rw), .uncached(uncached), .c_ready(c_ready),
    .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
    .m_strobe(m_strobe), .m_rw(m_rw), .m_ready(m_ready),
    .wb_empty(wb_empty), .wb_count(wb_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // memory responder + write scoreboard
  initial begin
    int busy;
    logic [W-1:0] e;
    busy = 0;
    m_ready = 1'b0;
    m_dout = '0;
    forever begin
      @(negedge clk);
      if (m_ready || !clrn || !m_strobe) begin
        m_ready = 1'b0;
        m_dout  = '0;
        busy    = 0;
      end else if (!mem_hold) begin
        if (busy < mem_wait) busy++;
        else begin
          busy = 0;
          m_ready = 1'b1;
          if (m_rw) begin
            total_wr++;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL mem_write unexpected got a=%h d=%h required none", m_a, m_din);
            end else begin
              e = exp_q.pop_front();
              if ({m_a, m_din} !== e) begin
                failures++;
                $display("FAIL mem_write_order got %h required %h", {m_a, m_din}, e);
              end
            end
          end else begin
            rd_log.push_back(m_a);
            rd_wcnt.push_back(total_wr);
            m_dout = mem_val(m_a);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cache_write(input logic [31:0] a, input logic [31:0] d, output int waits);
    @(negedge clk);
    c_strobe = 1'b1; c_rw = 1'b1; uncached = 1'b0; c_a = a; c_din = d;
    waits = 0;
    #1;
    while (!c_ready && waits < 300) begin
      @(negedge clk); #1;
      waits++;
    end
    checks++;
    if (!c_ready) begin
      failures++;
      $display("FAIL write_accept a=%h got c_ready=0 after %0d cycles required 1", a, waits);
    end else exp_q.push_back({a, d});
    @(posedge clk); #1;
    c_strobe = 1'b0;
  endtask

  task automatic cache_read(input logic [31:0] a, input logic unc,
                            output logic [31:0] d, output int waits);
    @(negedge clk);
    c_strobe = 1'b1; c_rw = 1'b0; uncached = unc; c_a = a; c_din = '0;
    waits = 0;
    #1;
    while (!c_ready && waits < 300) begin
      @(negedge clk); #1;
      waits++;
    end
    checks++;
    if (!c_ready) begin
      failures++;
      $display("FAIL read_accept a=%h got c_ready=0 after %0d cycles required 1", a, waits);
    end
    d = c_dout;
    @(posedge clk); #1;
    c_strobe = 1'b0; uncached = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(wb_empty && !m_strobe && !m_ready) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL drain_timeout got wb_count=%0d required 0", wb_count);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    int w;
    clrn = 1'b0; c_strobe = 1'b0; c_rw = 1'b0; c_a = '0; c_din = '0; uncached = 1'b0;
    mem_hold = 0; mem_wait = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_strobe, m_rw, wb_empty, wb_count, c_ready} !== {1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_flags got %b required 0010000",
               {m_strobe, m_rw, wb_empty, wb_count, c_ready});
    end
    checks++;
    if ({m_a, m_din, c_dout} !== 96'd0) begin
      failures++;
      $display("FAIL reset_data got m_a=%h m_din=%h c_dout=%h required 0", m_a, m_din, c_dout);
    end
    @(negedge clk);
    clrn = 1'b1;
    mem_hold = 1;
    cache_write(32'h0000_0300, 32'h1234_5678, w);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_strobe, m_rw, dbg_state, m_a, m_din} !== {1'b1, 1'b1, 2'd2, 32'h300, 32'h1234_5678}) begin
      failures++;
      $display("FAIL drain_start got strobe=%b rw=%b st=%0d a=%h d=%h required 1 1 2 300 12345678",
               m_strobe, m_rw, dbg_state, m_a, m_din);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if ({m_strobe, wb_empty, wb_count, m_a} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_mid_write got strobe=%b empty=%b count=%0d m_a=%h required 0 1 0 0",
               m_strobe, wb_empty, wb_count, m_a);
    end
    exp_q.delete();
    @(negedge clk);
    clrn = 1'b1;
    mem_hold = 0;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (total_wr !== 0 || m_strobe !== 1'b0) begin
      failures++;
      $display("FAIL dropped_entry got writes=%0d strobe=%b required 0 0", total_wr, m_strobe);
    end
  endtask

  task automatic test_forward();
    int w;
    int nrd;
    logic [31:0] d;
    nrd = rd_log.size();
    mem_hold = 1;
    cache_write(32'h0000_0100, 32'hAAAA_0001, w);
    cache_write(32'h0000_0100, 32'hAAAA_0002, w);
    cache_read(32'h0000_0100, 1'b0, d, w);
    checks++;
    if (w !== 0 || d !== 32'hAAAA_0002) begin
      failures++;
      $display("FAIL fwd_youngest got waits=%0d d=%h required 0 aaaa0002", w, d);
    end
    cache_read(32'h0000_0103, 1'b0, d, w);
    checks++;
    if (w !== 0 || d !== 32'hAAAA_0002) begin
      failures++;
      $display("FAIL fwd_low_bits got waits=%0d d=%h required 0 aaaa0002", w, d);
    end
    cache_write(32'h0000_0104, 32'hBBBB_0003, w);
    cache_read(32'h0000_0104, 1'b0, d, w);
    checks++;
    if (w !== 0 || d !== 32'hBBBB_0003) begin
      failures++;
      $display("FAIL fwd_other got waits=%0d d=%h required 0 bbbb0003", w, d);
    end
    checks++;
    if (rd_log.size() !== nrd) begin
      failures++;
      $display("FAIL fwd_no_mem_read got %0d reads required %0d", rd_log.size(), nrd);
    end
    mem_hold = 0;
    wait_drained();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL fwd_drained got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    mem_hold = 1;
    mem_wait = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cache_write(32'h0000_0400 + 32'(i * 4), 32'h4400_0000 + 32'(i), w);
      checks++;
      if (w !== 0) begin
        failures++;
        $display("FAIL b2b_accept_%0d got waits=%0d required 0", i, w);
      end
    end
    @(negedge clk);
    c_strobe = 1'b1; c_rw = 1'b1; c_a = 32'h0000_0410; c_din = 32'h4400_0004;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (c_ready !== 1'b0 || wb_count !== 3'd4 || wb_empty !== 1'b0) begin
        failures++;
        $display("FAIL full_stall_%0d got ready=%b count=%0d required 0 4", k, c_ready, wb_count);
      end
      @(negedge clk); #1;
    end
    mem_hold = 0;
    @(negedge clk); #1;
    checks++;
    if (m_ready !== 1'b1 || c_ready !== 1'b0 || wb_count !== 3'd4) begin
      failures++;
      $display("FAIL pop_no_unblock got m_ready=%b ready=%b count=%0d required 1 0 4",
               m_ready, c_ready, wb_count);
    end
    @(negedge clk); #1;
    checks++;
    if (c_ready !== 1'b1 || wb_count !== 3'd3) begin
      failures++;
      $display("FAIL after_pop got ready=%b count=%0d required 1 3", c_ready, wb_count);
    end
    exp_q.push_back({32'h0000_0410, 32'h4400_0004});
    @(posedge clk); #1;
    c_strobe = 1'b0;
    checks++;
    if (wb_count !== 3'd4) begin
      failures++;
      $display("FAIL refill got count=%0d required 4", wb_count);
    end
    wait_drained();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_drained got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_read_miss();
    int w;
    int nwr;
    logic [31:0] d;
    mem_wait = 0;
    cache_read(32'h0000_0200, 1'b0, d, w);
    checks++;
    if (w !== 1 || d !== mem_val(32'h0000_0200)) begin
      failures++;
      $display("FAIL miss_latency got waits=%0d d=%h required 1 %h", w, d, mem_val(32'h200));
    end
    nwr = total_wr;
    cache_write(32'h0000_0500, 32'h5500_0001, w);
    cache_write(32'h0000_0504, 32'h5500_0002, w);
    cache_read(32'h0000_0200, 1'b0, d, w);
    checks++;
    if (d !== mem_val(32'h0000_0200)) begin
      failures++;
      $display("FAIL miss_data got %h required %h", d, mem_val(32'h200));
    end
    checks++;
    if (rd_log.size() == 0 || rd_log[$] !== 32'h0000_0200 || rd_wcnt[$] !== nwr + 1) begin
      failures++;
      $display("FAIL miss_bypass got reads=%0d writes_before=%0d required addr 200 writes_before=%0d",
               rd_log.size(), (rd_wcnt.size() != 0) ? rd_wcnt[$] : -1, nwr + 1);
    end
    wait_drained();
    checks++;
    if (total_wr !== nwr + 2 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL miss_drain got writes=%0d required %0d", total_wr, nwr + 2);
    end
  endtask

  task automatic test_uncached();
    int w;
    int nwr;
    logic [31:0] d;
    nwr = total_wr;
    mem_wait = 1;
    cache_write(32'hBF00_0000, 32'hCC00_0001, w);
    cache_write(32'h0000_0600, 32'hCC00_0002, w);
    cache_read(32'hBF00_0000, 1'b1, d, w);
    checks++;
    if (d !== mem_val(32'hBF00_0000)) begin
      failures++;
      $display("FAIL unc_data got %h required %h", d, mem_val(32'hBF00_0000));
    end
    checks++;
    if (rd_log.size() == 0 || rd_log[$] !== 32'hBF00_0000 || rd_wcnt[$] !== nwr + 2) begin
      failures++;
      $display("FAIL unc_order got writes_before=%0d required addr bf000000 writes_before=%0d",
               (rd_wcnt.size() != 0) ? rd_wcnt[$] : -1, nwr + 2);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL unc_drained got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int w;
    logic [31:0] a;
    logic [31:0] d;
    mem_hold = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      mem_wait = $urandom_range(0, 2);
      cache_write(32'h0000_1000 + 32'(i * 4), $urandom, w);
      if ($urandom_range(0, 2) == 0) begin
        a = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
        cache_read(a, 1'b0, d, w);
        checks++;
        if (d !== mem_val(a)) begin
          failures++;
          $display("FAIL wrap_read a=%h got %h required %h", a, d, mem_val(a));
        end
      end
    end
    wait_drained();
    checks++;
    if (exp_q.size() !== 0 || wb_count !== 3'd0) begin
      failures++;
      $display("FAIL wrap_drained got pending=%0d count=%0d required 0 0", exp_q.size(), wb_count);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_read_miss();
    test_uncached();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
